// File: rtl/bcd_conv_16b.sv
// rtl/bcd_conv_16b.sv - sequential double-dabble converter for divider quotient/remainder
// Converts both captured operands in parallel; results publish only on completion.
module bcd_conv_16b #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      quot,
  input  logic [WIDTH-1:0]      rem,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   quot_bcd,
  output logic [4*DIGITS-1:0]   rem_bcd,
  output logic                  inf
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             armed;
  logic             accept, done;
  logic [WIDTH-1:0] q_sr, r_sr, q_cap;
  logic [BW-1:0]    q_acc, r_acc, q_adj, r_adj, q_shift, r_shift;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5) r[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Adjust then shift in one cycle; the shifted value is also the final result.
  assign q_adj   = add3(q_acc);
  assign r_adj   = add3(r_acc);
  assign q_shift = {q_adj[BW-2:0], q_sr[WIDTH-1]};
  assign r_shift = {r_adj[BW-2:0], r_sr[WIDTH-1]};
  assign ready   = (state == IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && armed) begin
          accept    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (cnt == 4'd15) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      armed    <= 1'b1;
      q_sr     <= '0;
      r_sr     <= '0;
      q_cap    <= '0;
      q_acc    <= '0;
      r_acc    <= '0;
      quot_bcd <= '0;
      rem_bcd  <= '0;
      inf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && !start) armed <= 1'b1;
      if (accept) begin
        q_sr  <= quot;
        r_sr  <= rem;
        q_cap <= quot;
        q_acc <= '0;
        r_acc <= '0;
        cnt   <= 4'd0;
        armed <= 1'b0;
      end
      if (state == CONV) begin
        q_acc <= q_shift;
        r_acc <= r_shift;
        q_sr  <= {q_sr[WIDTH-2:0], 1'b0};
        r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
        cnt   <= cnt + 4'd1;
      end
      if (done) begin
        quot_bcd <= q_shift;
        rem_bcd  <= r_shift;
        inf      <= (q_cap == {WIDTH{1'b1}});
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_16b.sv
// tb/tb_bcd_conv_16b.sv - self-checking bench for bcd_conv_16b
// Expected BCD comes from decimal digit arithmetic; stimulus mixes directed and random operands.
module tb_bcd_conv_16b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] quot = '0;
  logic [15:0] rem = '0;
  logic        ready;
  logic [19:0] quot_bcd, rem_bcd;
  logic        inf;

  int checks = 0;
  int failures = 0;
  int busy = 0;
  logic [19:0] prev_q = '0, prev_r = '0;

  bcd_conv_16b dut (
    .clk(clk), .rst_n(rst_n), .start(start), .quot(quot), .rem(rem),
    .ready(ready), .quot_bcd(quot_bcd), .rem_bcd(rem_bcd), .inf(inf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r = r | (20'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic accept(input logic [15:0] q, input logic [15:0] r, input bit hold);
    quot  = q;
    rem   = r;
    start = 1'b1;
    @(negedge clk);
    check("accept_ready", ready, 0);
    check("hold_quot_bcd", quot_bcd, prev_q);
    check("hold_rem_bcd", rem_bcd, prev_r);
    if (!hold) start = 1'b0;
    busy = 1;
  endtask

  task automatic run_cycles(input int k);
    repeat (k) begin
      @(negedge clk);
      if (!ready) busy++;
    end
  endtask

  task automatic finish(input logic [15:0] q, input logic [15:0] r);
    while (busy < 40) begin
      @(negedge clk);
      if (ready) break;
      busy++;
    end
    check("busy_cycles", busy, 16);
    prev_q = to_bcd(q);
    prev_r = to_bcd(r);
    check("quot_bcd", quot_bcd, prev_q);
    check("rem_bcd", rem_bcd, prev_r);
    check("inf", inf, (q == 16'hFFFF));
  endtask

  task automatic convert(input logic [15:0] q, input logic [15:0] r);
    accept(q, r, 1'b0);
    finish(q, r);
    @(negedge clk);
  endtask

  task automatic divide_then_convert(input int unsigned a, input int unsigned b);
    logic [15:0] q, r;
    if (b == 0) begin
      q = 16'hFFFF;
      r = 16'(a);
    end else begin
      q = 16'(a / b);
      r = 16'(a % b);
    end
    convert(q, r);
  endtask

  initial begin
    logic [15:0] rq, rr;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_quot_bcd", quot_bcd, 0);
    check("rst_rem_bcd", rem_bcd, 0);
    check("rst_inf", inf, 0);
    repeat (5) @(negedge clk);
    check("idle_ready", ready, 1);
    check("idle_quot_bcd", quot_bcd, 0);

    convert(16'd12345, 16'd678);
    check("basic_q_lit", quot_bcd, 20'h12345);
    convert(16'd0, 16'd65535);
    check("bound_r_lit", rem_bcd, 20'h65535);
    convert(16'hFFFF, 16'd9);
    check("bound_q_lit", quot_bcd, 20'h65535);
    check("bound_inf", inf, 1);

    // Held start: one conversion only, then re-arm after a one-cycle drop.
    accept(16'd4321, 16'd99, 1'b1);
    finish(16'd4321, 16'd99);
    repeat (3) begin
      @(negedge clk);
      check("held_no_retrigger", ready, 1);
    end
    start = 1'b0;
    @(negedge clk);
    accept(16'd777, 16'd1, 1'b0);
    finish(16'd777, 16'd1);
    @(negedge clk);

    // Inputs and start disturbed mid-conversion.
    accept(16'd2024, 16'd5001, 1'b0);
    run_cycles(4);
    quot  = 16'd9999;
    rem   = 16'd1111;
    start = 1'b1;
    run_cycles(1);
    start = 1'b0;
    finish(16'd2024, 16'd5001);
    @(negedge clk);

    // Reset during conversion discards everything.
    accept(16'd31415, 16'd27182, 1'b0);
    run_cycles(6);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", ready, 1);
    check("midrst_quot_bcd", quot_bcd, 0);
    check("midrst_rem_bcd", rem_bcd, 0);
    check("midrst_inf", inf, 0);
    rst_n = 1'b1;
    prev_q = '0;
    prev_r = '0;
    @(negedge clk);

    divide_then_convert(1000, 7);
    check("div_q_lit", quot_bcd, 20'h00142);
    check("div_r_lit", rem_bcd, 20'h00006);
    divide_then_convert(1000, 0);
    check("div0_inf", inf, 1);
    check("div0_rem", rem_bcd, 20'h01000);

    for (int i = 0; i < 20; i++) begin
      rq = 16'($urandom);
      rr = 16'($urandom);
      convert(rq, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
